// File: rtl/extmem_arbiter.sv
// extmem_arbiter: round-robin arbiter sharing one external memory among NUM_REQ requesters.
// Burst-lock (LOCK state, burst counter) is compiled in by defining EXTMEM_ARB_BURST_EN.
`ifndef ADDR_EXT_RAM
`define ADDR_EXT_RAM 16
`endif
`ifndef DATA_EXT_RAM
`define DATA_EXT_RAM 32
`endif
module extmem_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = `ADDR_EXT_RAM,
  parameter int DATA_W    = `DATA_EXT_RAM,
  parameter int MAX_BURST = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ-1:0]         req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         rvalid,
  output logic [DATA_W-1:0]          rdata,
  output logic                       mem_re,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_rd_addr,
  output logic [ADDR_W-1:0]          mem_wr_addr,
  output logic [DATA_W-1:0]          mem_wr_data,
  input  logic [DATA_W-1:0]          mem_rd_data
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, ARB, LOCK} state_t;
  state_t              r_state;
  logic [IW-1:0]       r_ptr, r_tag1, w_idx;
  logic                r_tag1_v, w_found, w_xfer, w_we, w_hold;
  logic [NUM_REQ-1:0]  r_rvalid;
  logic                r_mem_re, r_mem_we;
  logic [ADDR_W-1:0]   r_mem_rd_addr, r_mem_wr_addr;
  logic [DATA_W-1:0]   r_mem_wr_data;
`ifdef EXTMEM_ARB_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [IW-1:0]       r_owner;
  logic [CW-1:0]       r_cnt;
  assign w_hold = r_state == LOCK && req[r_owner] && req_lock[r_owner] && r_cnt < CW'(MAX_BURST);
`else
  logic                w_unused_lock;
  assign w_unused_lock = ^req_lock;
  assign w_hold = 1'b0;
`endif
  // A held lock overrides the round-robin search, which starts at r_ptr.
  always_comb begin
    w_found = 1'b0;
    w_idx = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (!w_found && req[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_idx = IW'((int'(r_ptr) + k) % NUM_REQ);
      end
`ifdef EXTMEM_ARB_BURST_EN
    if (w_hold) begin
      w_found = 1'b1;
      w_idx = r_owner;
    end
`endif
  end
  assign w_xfer = w_found & rst_n;
  assign w_we   = req_we[w_idx];
  assign gnt    = w_xfer ? NUM_REQ'(1) << w_idx : '0;
  assign rvalid = r_rvalid;
  assign rdata  = |r_rvalid ? mem_rd_data : '0;
  assign mem_re = r_mem_re;
  assign mem_we = r_mem_we;
  assign mem_rd_addr = r_mem_rd_addr;
  assign mem_wr_addr = r_mem_wr_addr;
  assign mem_wr_data = r_mem_wr_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_tag1        <= '0;
      r_tag1_v      <= 1'b0;
      r_rvalid      <= '0;
      r_mem_re      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_rd_addr <= '0;
      r_mem_wr_addr <= '0;
      r_mem_wr_data <= '0;
`ifdef EXTMEM_ARB_BURST_EN
      r_owner       <= '0;
      r_cnt         <= '0;
`endif
    end else begin
      r_mem_re <= w_xfer & ~w_we;
      r_mem_we <= w_xfer & w_we;
      if (w_xfer & ~w_we) r_mem_rd_addr <= req_addr[w_idx*ADDR_W +: ADDR_W];
      if (w_xfer & w_we) begin
        r_mem_wr_addr <= req_addr[w_idx*ADDR_W +: ADDR_W];
        r_mem_wr_data <= req_wdata[w_idx*DATA_W +: DATA_W];
      end
      r_tag1_v <= w_xfer & ~w_we;
      r_tag1   <= w_idx;
      r_rvalid <= r_tag1_v ? NUM_REQ'(1) << r_tag1 : '0;
      if (w_xfer) r_ptr <= w_idx == IW'(NUM_REQ - 1) ? '0 : w_idx + 1'b1;
`ifdef EXTMEM_ARB_BURST_EN
      if (w_xfer && (w_hold || req_lock[w_idx])) begin
        r_state <= LOCK;
        r_owner <= w_idx;
        r_cnt   <= w_hold ? r_cnt + 1'b1 : CW'(1);
      end else
`endif
      r_state <= (w_xfer || r_state == LOCK) ? ARB : IDLE;
    end
  end
endmodule

// File: tb/tb_extmem_arbiter.sv
// tb_extmem_arbiter: directed + random checks of extmem_arbiter against a transaction-level model.
// Define EXTMEM_ARB_BURST_EN to exercise the burst-lock build.
module tb_extmem_arbiter;
  localparam int N = 3, AW = 8, DW = 8, MB = 4;
  logic clk = 0, rst_n = 0;
  logic [N-1:0] req = '0, req_we = '0, req_lock = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0] gnt, rvalid;
  logic [DW-1:0] rdata, mem_wr_data;
  logic mem_re, mem_we;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic [DW-1:0] dev [256];
  logic [255:0] wr_seen = '0;
  logic [DW-1:0] model_mem [256];
  typedef struct { int due; int idx; logic [DW-1:0] data; } rd_t;
  rd_t pend [$];
  int checks = 0, failures = 0, cyc = 0, ptr = 0, owner = -1, cnt = 0;
  logic prev_re = 0, prev_we = 0;
  logic [AW-1:0] prev_ra = '0, prev_wa = '0;
  logic [DW-1:0] prev_wd = '0;
  logic [N-1:0] g_seen;
  logic [N-1:0] exp_seq [6];

  extmem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data));

  always #5 clk = ~clk;

  // Synchronous memory; unwritten words read as addr ^ 0xA0.
  always @(posedge clk) begin
    if (mem_we) begin
      dev[mem_wr_addr] <= mem_wr_data;
      wr_seen[mem_wr_addr] <= 1'b1;
    end
    if (mem_re) mem_rd_data <= wr_seen[mem_rd_addr] ? dev[mem_rd_addr] : (mem_rd_addr ^ 8'hA0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] w, input logic [N-1:0] l,
                      input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
    int g;
    bit held;
    logic [N-1:0] erv;
    logic [DW-1:0] erd;
    @(negedge clk);
    req = r; req_we = w; req_lock = l; req_addr = a; req_wdata = d;
    #1;
    g = -1;
    held = 0;
`ifdef EXTMEM_ARB_BURST_EN
    if (owner >= 0 && r[owner] && l[owner] && cnt < MB) begin g = owner; held = 1; end
`endif
    for (int k = 0; k < N && g < 0; k++) if (r[(ptr + k) % N]) g = (ptr + k) % N;
    g_seen = gnt;
    chk("gnt", gnt, g < 0 ? 0 : 1 << g);
    chk("mem_re", mem_re, prev_re);
    chk("mem_we", mem_we, prev_we);
    if (prev_re) chk("mem_rd_addr", mem_rd_addr, prev_ra);
    if (prev_we) begin
      chk("mem_wr_addr", mem_wr_addr, prev_wa);
      chk("mem_wr_data", mem_wr_data, prev_wd);
    end
    erv = '0;
    erd = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      erv = N'(1) << pend[0].idx;
      erd = pend[0].data;
      void'(pend.pop_front());
    end
    chk("rvalid", rvalid, erv);
    if (erv != 0) chk("rdata", rdata, erd);
    prev_re = g >= 0 && !w[g];
    prev_we = g >= 0 && w[g];
    if (g >= 0) begin
      if (w[g]) begin
        prev_wa = a[g*AW +: AW];
        prev_wd = d[g*DW +: DW];
        model_mem[prev_wa] = prev_wd;
      end else begin
        prev_ra = a[g*AW +: AW];
        pend.push_back('{cyc + 2, g, model_mem[prev_ra]});
      end
      ptr = (g + 1) % N;
      if (held) cnt++;
      else if (l[g]) begin owner = g; cnt = 1; end
      else owner = -1;
    end else owner = -1;
    cyc++;
  endtask

  task automatic idle();
    step('0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    req = '1; req_we = '0; req_lock = '0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_rvalid", rvalid, 0);
    @(negedge clk);
    req = '0;
    rst_n = 1;
    pend.delete();
    ptr = 0; owner = -1; cnt = 0; prev_re = 0; prev_we = 0;
  endtask

  initial begin
    logic [N*AW-1:0] ra;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'(i) ^ 8'hA0;
    do_reset();
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int i = 0; i < 6; i++) begin
      step(3'b111, 3'b000, 3'b000, {8'd2, 8'd1, 8'd0}, '0);
      chk("rr_seq", g_seen, exp_seq[i]);
    end
    idle(); idle();
    step(3'b010, 3'b000, 3'b000, {8'd0, 8'd5, 8'd0}, '0);
    idle();
    chk("lat_mem_re", mem_re, 1);
    chk("lat_rd_addr", mem_rd_addr, 5);
    idle();
    chk("lat_rvalid", rvalid, 3'b010);
    chk("lat_rdata", rdata, 8'hA5);
    step(3'b001, 3'b001, 3'b000, {8'd0, 8'd0, 8'd7}, {8'd0, 8'd0, 8'h3C});
    step(3'b100, 3'b000, 3'b000, {8'd7, 8'd0, 8'd0}, '0);
    idle(); idle();
    chk("wr_rd_rvalid", rvalid, 3'b100);
    chk("wr_rd_rdata", rdata, 8'h3C);
`ifdef EXTMEM_ARB_BURST_EN
    exp_seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001};
`else
    exp_seq = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
`endif
    for (int i = 0; i < 6; i++) begin
      step(3'b011, 3'b000, 3'b001, {8'd0, 8'd9, 8'd8}, '0);
      chk("burst_seq", g_seen, exp_seq[i]);
    end
    idle(); idle();
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < N; j++) ra[j*AW +: AW] = AW'($urandom_range(0, 15));
      step(N'($urandom), N'($urandom), N'($urandom), ra, (N*DW)'($urandom));
    end
    idle(); idle();
    step(3'b010, 3'b000, 3'b000, {8'd0, 8'd5, 8'd0}, '0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("rst_mid_rvalid", rvalid, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
